// File: rtl/semimips_pkg.sv
// Shared semiMIPS control-bundle definitions: field layout, bubble constant, counter width.
package semimips_pkg;

    localparam int CTRL_W    = 4;
    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic memtoreg;
        logic regwr;
        logic memwr;
        logic branch;
    } ctrl_t;

    // A bubble must never write the register file or memory.
    localparam ctrl_t NOP = '{memtoreg: 1'b0, regwr: 1'b0, memwr: 1'b0, branch: 1'b0};

endpackage

// File: rtl/ctrlpipe_if.sv
// Handshake bundle between hazard/decode logic and the control pipeline.
interface ctrlpipe_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
);
    logic                   stall;
    logic [DEPTH-1:0]       flush;
    logic                   validin;
    logic [WIDTH-1:0]       datain;
    logic [DEPTH-1:0]       validout;
    logic [DEPTH*WIDTH-1:0] dataout;

    modport master (
        output stall, flush, validin, datain,
        input  validout, dataout
    );

    modport slave (
        input  stall, flush, validin, datain,
        output validout, dataout
    );
endinterface

// File: rtl/ctrlpipe_stage.sv
// One {valid, data} control register with reset > flush > stall > advance priority.
module ctrlpipe_stage #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Flush wins over stall so hazard logic can kill a frozen stage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= 1'b0;
            data  <= NOP_VAL;
        end else if (!stall) begin
            valid <= prev_valid;
            data  <= prev_data;
        end
    end

endmodule

// File: rtl/ctrlpipe.sv
// DEPTH-stage control pipeline with global stall and per-stage flush.
// Optional performance counters are built when CTRLPIPE_PERF_EN is defined.
module ctrlpipe
    import semimips_pkg::*;
#(
    parameter int               WIDTH   = CTRL_W,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] NOP_VAL = WIDTH'(NOP),
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    ctrlpipe_if.slave  bus
`ifdef CTRLPIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH*WIDTH-1:0] data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] pd;

        // Stage 0 substitutes NOP_VAL for invalid input so bubbles stay inert downstream.
        if (i == 0) begin : g_head
            assign pv = bus.validin;
            assign pd = bus.validin ? bus.datain : NOP_VAL;
        end else begin : g_body
            assign pv = valid_q[i-1];
            assign pd = data_q[(i-1)*WIDTH +: WIDTH];
        end

        ctrlpipe_stage #(
            .WIDTH   (WIDTH),
            .NOP_VAL (NOP_VAL)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .stall      (bus.stall),
            .flush      (bus.flush[i]),
            .prev_valid (pv),
            .prev_data  (pd),
            .valid      (valid_q[i]),
            .data       (data_q[i*WIDTH +: WIDTH])
        );
    end

    assign bus.validout = valid_q;
    assign bus.dataout  = data_q;

`ifdef CTRLPIPE_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (bus.stall)
                stall_cnt <= sat_inc(stall_cnt);
            if (!valid_q[DEPTH-1])
                bubble_cnt <= sat_inc(bubble_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_ctrlpipe.sv
// Directed bench for ctrlpipe (WIDTH=4, DEPTH=3, NOP_VAL=0); counter checks with CTRLPIPE_PERF_EN.
module tb_ctrlpipe;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ctrlpipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef CTRLPIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
`endif

    ctrlpipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .NOP_VAL (4'h0),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef CTRLPIPE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_pipe(input string tag, input logic [2:0] v, input logic [11:0] d);
        check({tag, "_valid"}, 32'(bus.validout), 32'(v));
        check({tag, "_data"},  32'(bus.dataout),  32'(d));
    endtask

    initial begin
        rst         = 1'b1;
        bus.stall   = 1'b0;
        bus.flush   = 3'b000;
        bus.validin = 1'b0;
        bus.datain  = 4'h0;

        // Reset for two edges.
        step();
        step();
        expect_pipe("reset", 3'b000, 12'h000);

        // Stream 1,2,3 (dataout = {st2, st1, st0}).
        rst = 1'b0;
        bus.validin = 1'b1;
        bus.datain  = 4'h1; step(); expect_pipe("stream1", 3'b001, 12'h001);
        bus.datain  = 4'h2; step(); expect_pipe("stream2", 3'b011, 12'h012);
        bus.datain  = 4'h3; step(); expect_pipe("stream3", 3'b111, 12'h123);

        // Stall holds {3,2,1} while 9 waits at the input.
        bus.stall  = 1'b1;
        bus.datain = 4'h9;
        step(); expect_pipe("stall_a", 3'b111, 12'h123);
        step(); expect_pipe("stall_b", 3'b111, 12'h123);
        bus.stall = 1'b0;
        step(); expect_pipe("stall_rel", 3'b111, 12'h239);
        bus.datain = 4'h4;
        step(); expect_pipe("stream4", 3'b111, 12'h394);

        // Build {st0,st1,st2} = {5,6,7}, then flush stage 1 under stall.
        bus.datain = 4'h7; step();
        bus.datain = 4'h6; step();
        bus.datain = 4'h5; step(); expect_pipe("fill567", 3'b111, 12'h765);
        bus.stall = 1'b1;
        bus.flush = 3'b010;
        step(); expect_pipe("flush_stall", 3'b101, 12'h705);
        bus.flush = 3'b000;
        step(); expect_pipe("hold_after_flush", 3'b101, 12'h705);

        // Invalid input with all-ones data must never leak.
        bus.stall   = 1'b0;
        bus.validin = 1'b0;
        bus.datain  = 4'hF;
        step(); expect_pipe("invalid_a", 3'b010, 12'h050);
        step(); expect_pipe("invalid_b", 3'b100, 12'h500);
        step(); expect_pipe("invalid_c", 3'b000, 12'h000);

        // Flush of last stage does not disturb upstream advance.
        bus.validin = 1'b1;
        bus.datain = 4'h1; step();
        bus.datain = 4'h2; step();
        bus.datain = 4'h3; step(); expect_pipe("refill", 3'b111, 12'h123);
        bus.flush  = 3'b100;
        bus.datain = 4'h4;
        step(); expect_pipe("flush_last", 3'b011, 12'h034);
        bus.flush  = 3'b000;
        bus.datain = 4'h5;
        step(); expect_pipe("after_flush_last", 3'b111, 12'h345);

        // Reset wins over stall on a full pipe.
        bus.stall = 1'b1;
        rst = 1'b1;
        step(); expect_pipe("mid_reset", 3'b000, 12'h000);
        rst = 1'b0;
        bus.stall  = 1'b0;
        bus.datain = 4'hA;
        step(); expect_pipe("post_reset", 3'b001, 12'h00A);

`ifdef CTRLPIPE_PERF_EN
        rst = 1'b1;
        bus.validin = 1'b0;
        step();
        check("cnt_reset_stall",  32'(stall_cnt),  32'h0);
        check("cnt_reset_bubble", 32'(bubble_cnt), 32'h0);
        rst = 1'b0;
        bus.validin = 1'b1;
        bus.datain  = 4'h3;
        for (int i = 0; i < 4; i++) step();
        check("bubble_cnt_fill", 32'(bubble_cnt), 32'h3);
        check("stall_cnt_idle",  32'(stall_cnt),  32'h0);
        bus.stall = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("stall_cnt_sat",     32'(stall_cnt),  32'hF);
        check("bubble_cnt_stable", 32'(bubble_cnt), 32'h3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
